// File: rtl/bar_shift_pipe.sv
// Pipelined barrel shifter: SLL/ROL/SRL/SRA on a WIDTH-bit operand, one mux layer per
// register stage, with a last-bit-out carry and a zero flag for the ALU flag logic.
module bar_shift_pipe #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW:0]     in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero
);

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_ROL = 2'b01,
    OP_SRL = 2'b10,
    OP_SRA = 2'b11
  } op_e;

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] x);
    for (int i = 0; i < WIDTH; i++) begin
      bit_rev[i] = x[WIDTH-1-i];
    end
  endfunction

  logic en;

  // Capture-side values feeding layer 0.
  logic             c_rot;
  logic             c_rev;
  logic             c_fill;
  logic             c_carry;
  logic             ge_w;
  logic [SHW-1:0]   c_amt;
  logic [WIDTH-1:0] c_data;
  logic [SHW-1:0]   sll_idx;
  logic [SHW-1:0]   srl_idx;

  // Per-layer inputs (from capture or the previous stage register) and layer outputs.
  logic [WIDTH-1:0] l_data  [SHW];
  logic [WIDTH-1:0] l_out   [SHW];
  logic [SHW-1:0]   l_amt   [SHW];
  logic             l_rot   [SHW];
  logic             l_rev   [SHW];
  logic             l_fill  [SHW];
  logic             l_carry [SHW];
  logic [WIDTH-1:0] fin_data;

  // Stage registers; control fields are only needed by the layers that follow them.
  logic             st_valid [SHW];
  logic [WIDTH-1:0] st_data  [SHW];
  logic             st_carry [SHW];
  logic             st_zero;
  logic [SHW-1:0]   st_amt   [SHW-1];
  logic             st_rot   [SHW-1];
  logic             st_rev   [SHW-1];
  logic             st_fill  [SHW-1];

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  // Bit index of the last bit shifted out, valid for 1 <= amt <= WIDTH.
  assign sll_idx = SHW'((SHW+1)'(WIDTH) - in_amt);
  assign srl_idx = SHW'(in_amt - (SHW+1)'(1));

  always_comb begin
    c_rot  = (in_op == OP_ROL);
    c_rev  = ~in_op[1];
    c_fill = (in_op == OP_SRA) & in_data[WIDTH-1];
    ge_w   = in_amt[SHW];
    c_amt  = in_amt[SHW-1:0];
    c_data = c_rev ? bit_rev(in_data) : in_data;
    // Oversized non-rotate shifts saturate to the fill pattern; layers then pass it through.
    if (ge_w && !c_rot) begin
      c_amt  = '0;
      c_data = {WIDTH{c_fill}};
    end
    c_carry = 1'b0;
    if (in_amt != '0 && !c_rot) begin
      if (in_amt > (SHW+1)'(WIDTH)) begin
        c_carry = c_fill;
      end else if (c_rev) begin
        c_carry = in_data[sll_idx];
      end else begin
        c_carry = in_data[srl_idx];
      end
    end
  end

  for (genvar k = 0; k < SHW; k++) begin : g_layer
    localparam int SH = 1 << (SHW - 1 - k);
    if (k == 0) begin : g_first
      assign l_data[k]  = c_data;
      assign l_amt[k]   = c_amt;
      assign l_rot[k]   = c_rot;
      assign l_rev[k]   = c_rev;
      assign l_fill[k]  = c_fill;
      assign l_carry[k] = c_carry;
    end else begin : g_next
      assign l_data[k]  = st_data[k-1];
      assign l_amt[k]   = st_amt[k-1];
      assign l_rot[k]   = st_rot[k-1];
      assign l_rev[k]   = st_rev[k-1];
      assign l_fill[k]  = st_fill[k-1];
      assign l_carry[k] = st_carry[k-1];
    end
    assign l_out[k] = !l_amt[k][SHW-1-k] ? l_data[k]
                    : l_rot[k] ? {l_data[k][SH-1:0], l_data[k][WIDTH-1:SH]}
                    : {{SH{l_fill[k]}}, l_data[k][WIDTH-1:SH]};
  end

  assign fin_data = l_rev[SHW-1] ? bit_rev(l_out[SHW-1]) : l_out[SHW-1];

  // NOTE: datapath registers are reset too because out_data/out_carry/out_zero must read 0 in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SHW; k++) begin
        st_valid[k] <= 1'b0;
        st_data[k]  <= '0;
        st_carry[k] <= 1'b0;
      end
      for (int k = 0; k < SHW - 1; k++) begin
        st_amt[k]  <= '0;
        st_rot[k]  <= 1'b0;
        st_rev[k]  <= 1'b0;
        st_fill[k] <= 1'b0;
      end
      st_zero <= 1'b0;
    end else if (en) begin
      st_valid[0] <= in_valid & in_ready;
      for (int k = 1; k < SHW; k++) begin
        st_valid[k] <= st_valid[k-1];
      end
      for (int k = 0; k < SHW - 1; k++) begin
        st_data[k]  <= l_out[k];
        st_carry[k] <= l_carry[k];
        st_amt[k]   <= l_amt[k];
        st_rot[k]   <= l_rot[k];
        st_rev[k]   <= l_rev[k];
        st_fill[k]  <= l_fill[k];
      end
      st_data[SHW-1]  <= fin_data;
      st_carry[SHW-1] <= l_carry[SHW-1];
      st_zero         <= (fin_data == '0);
    end
  end

  assign out_valid = st_valid[SHW-1];
  assign out_data  = st_data[SHW-1];
  assign out_carry = st_carry[SHW-1];
  assign out_zero  = st_zero;

endmodule

// File: tb/tb_bar_shift_pipe.sv
// Self-checking bench for bar_shift_pipe (WIDTH=16): directed vectors, streaming,
// backpressure, random traffic against an arithmetic reference model, and mid-stream reset.
module tb_bar_shift_pipe;

  localparam int W   = 16;
  localparam int LAT = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [4:0]    in_amt;
  logic [1:0]    in_op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_carry;
  logic          out_zero;

  int checks = 0;
  int errors = 0;

  // Expected results, packed as {zero, carry, data}.
  logic [17:0] exp_q[$];

  bar_shift_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference: shifts done on 64-bit integers; carry is the bit that crosses the edge.
  function automatic logic [17:0] ref_shift(input logic [15:0] x, input int amt, input logic [1:0] op);
    longint ux;
    longint sx;
    longint r;
    longint c;
    int n;
    ux = longint'(x);
    sx = longint'($signed(x));
    r = 0;
    c = 0;
    case (op)
      2'b00: begin
        r = (ux << amt) & 64'hFFFF;
        c = (amt == 0) ? 0 : ((ux << amt) >> 16) & 1;
      end
      2'b01: begin
        n = amt % 16;
        r = ((ux << n) | (ux >> (16 - n))) & 64'hFFFF;
        c = 0;
      end
      2'b10: begin
        r = ux >> amt;
        c = (amt == 0) ? 0 : ((ux << 1) >> amt) & 1;
      end
      default: begin
        r = (sx >>> amt) & 64'hFFFF;
        c = (amt == 0) ? 0 : ((sx <<< 1) >>> amt) & 1;
      end
    endcase
    ref_shift = {(r == 0), c[0], r[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_random();
    in_data = W'($urandom);
    in_amt  = 5'($urandom_range(0, 31));
    in_op   = 2'($urandom_range(0, 3));
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_data   = '0;
    in_amt    = '0;
    in_op     = '0;
    #2;
    checks++;
    if ({out_valid, out_carry, out_zero, out_data} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b carry=%b zero=%b data=%h, want all 0",
               out_valid, out_carry, out_zero, out_data);
    end
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [15:0] dv [8] = '{16'h8001, 16'h8000, 16'h8000, 16'h1234, 16'h8001, 16'h8001, 16'h00F0, 16'h00F0};
    logic [4:0]  av [8] = '{5'd1, 5'd4, 5'd16, 5'd31, 5'd4, 5'd20, 5'd20, 5'd0};
    logic [1:0]  ov [8] = '{2'b00, 2'b11, 2'b11, 2'b11, 2'b01, 2'b01, 2'b10, 2'b10};
    logic [17:0] ev [8] = '{{1'b0, 1'b1, 16'h0002}, {1'b0, 1'b0, 16'hF800}, {1'b0, 1'b1, 16'hFFFF},
                            {1'b1, 1'b0, 16'h0000}, {1'b0, 1'b0, 16'h0018}, {1'b0, 1'b0, 16'h0018},
                            {1'b1, 1'b0, 16'h0000}, {1'b0, 1'b0, 16'h00F0}};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = dv[i];
      in_amt   = av[i];
      in_op    = ov[i];
      tick();
      in_valid = 1'b0;
      drive_random();
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL directed_early[%0d]: out_valid=%b after 3 edges, want 0", i, out_valid);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || {out_zero, out_carry, out_data} !== ev[i]) begin
        errors++;
        $display("FAIL directed[%0d]: got valid=%b z=%b c=%b data=%h, want valid=1 z=%b c=%b data=%h",
                 i, out_valid, out_zero, out_carry, out_data, ev[i][17], ev[i][16], ev[i][15:0]);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL directed_single[%0d]: out_valid=%b one edge later, want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] exp;
    exp_q.delete();
    out_ready = 1'b1;
    for (int t = 1; t <= 14; t++) begin
      if (t <= 8) begin
        in_valid = 1'b1;
        drive_random();
        exp_q.push_back(ref_shift(in_data, int'(in_amt), in_op));
      end else begin
        in_valid = 1'b0;
      end
      tick();
      checks++;
      if (out_valid !== (t >= LAT && t < LAT + 8)) begin
        errors++;
        $display("FAIL stream_valid[edge %0d]: got %b, want %b", t, out_valid, (t >= LAT && t < LAT + 8));
      end
      if (out_valid === 1'b1 && exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        checks++;
        if ({out_zero, out_carry, out_data} !== exp) begin
          errors++;
          $display("FAIL stream_data[edge %0d]: got z=%b c=%b data=%h, want z=%b c=%b data=%h",
                   t, out_zero, out_carry, out_data, exp[17], exp[16], exp[15:0]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [17:0] head;
    exp_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      drive_random();
      #1;
      checks++;
      if (in_ready !== (i < LAT)) begin
        errors++;
        $display("FAIL bp_in_ready[%0d]: got %b, want %b", i, in_ready, (i < LAT));
      end
      if (i < LAT) exp_q.push_back(ref_shift(in_data, int'(in_amt), in_op));
      tick();
    end
    head = exp_q[0];
    for (int i = 0; i < 5; i++) begin
      drive_random();
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {out_zero, out_carry, out_data} !== head) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%b in_ready=%b z=%b c=%b data=%h, want 1/0 z=%b c=%b data=%h",
                 i, out_valid, in_ready, out_zero, out_carry, out_data, head[17], head[16], head[15:0]);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bp_extra: unexpected result data=%h", out_data);
        end else if ({out_zero, out_carry, out_data} !== exp_q[0]) begin
          errors++;
          $display("FAIL bp_drain: got z=%b c=%b data=%h, want z=%b c=%b data=%h",
                   out_zero, out_carry, out_data, exp_q[0][17], exp_q[0][16], exp_q[0][15:0]);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      tick();
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_lost: %0d results missing, want 0", exp_q.size());
    end
  endtask

  task automatic test_random();
    exp_q.delete();
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 9) < 6);
      in_valid  = ($urandom_range(0, 9) < 7);
      drive_random();
      #1;
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        errors++;
        $display("FAIL rand_in_ready[%0d]: got %b, want %b", i, in_ready, (!out_valid || out_ready));
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra[%0d]: unexpected result data=%h", i, out_data);
        end else if ({out_zero, out_carry, out_data} !== exp_q[0]) begin
          errors++;
          $display("FAIL rand_data[%0d]: got z=%b c=%b data=%h, want z=%b c=%b data=%h",
                   i, out_zero, out_carry, out_data, exp_q[0][17], exp_q[0][16], exp_q[0][15:0]);
        end
        if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (in_valid && in_ready) exp_q.push_back(ref_shift(in_data, int'(in_amt), in_op));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_drain_extra: unexpected result data=%h", out_data);
        end else if ({out_zero, out_carry, out_data} !== exp_q[0]) begin
          errors++;
          $display("FAIL rand_drain: got z=%b c=%b data=%h, want z=%b c=%b data=%h",
                   out_zero, out_carry, out_data, exp_q[0][17], exp_q[0][16], exp_q[0][15:0]);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      tick();
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rand_lost: %0d results missing, want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_midstream();
    logic [15:0] d [6];
    logic [17:0] exp;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d[i]     = W'($urandom) | 16'h0001;
      in_valid = 1'b1;
      in_data  = d[i];
      in_amt   = 5'd0;
      in_op    = 2'b10;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== d[2]) begin
      errors++;
      $display("FAIL midrst_pre: got valid=%b data=%h, want valid=1 data=%h", out_valid, out_data, d[2]);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_carry, out_zero, out_data} !== 19'd0) begin
      errors++;
      $display("FAIL midrst_async: got valid=%b carry=%b zero=%b data=%h, want all 0",
               out_valid, out_carry, out_zero, out_data);
    end
    tick();
    rst = 1'b0;
    in_valid = 1'b1;
    drive_random();
    exp = ref_shift(in_data, int'(in_amt), in_op);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_ready: got in_ready=%b, want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    for (int t = 2; t <= 8; t++) begin
      tick();
      checks++;
      if (out_valid !== (t == LAT)) begin
        errors++;
        $display("FAIL midrst_valid[edge %0d]: got %b, want %b", t, out_valid, (t == LAT));
      end
      if (t == LAT) begin
        checks++;
        if ({out_zero, out_carry, out_data} !== exp) begin
          errors++;
          $display("FAIL midrst_data: got z=%b c=%b data=%h, want z=%b c=%b data=%h",
                   out_zero, out_carry, out_data, exp[17], exp[16], exp[15:0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
